// File: rtl/counters_sequencer_if.sv
// Command port of the counters sequencer: a valid/ready command carrying
// both limits and the round count, plus an out-of-band abort.
interface counters_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int ROUNDS_W = 4
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [WIDTH-1:0]    cmd_limit1;
    logic [WIDTH-1:0]    cmd_limit2;
    logic [ROUNDS_W-1:0] cmd_rounds;
    logic                abort;

    modport master (
        output cmd_valid,
        output cmd_limit1,
        output cmd_limit2,
        output cmd_rounds,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_limit1,
        input  cmd_limit2,
        input  cmd_rounds,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/counters_sequencer.sv
// Runs counter 1 up to limit1, then counter 2 up to limit2, for a
// host-programmed number of rounds, then pulses done for one cycle.
module counters_sequencer #(
    parameter int WIDTH    = 8,
    parameter int ROUNDS_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    counters_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]    cnt1_out,
    output logic [WIDTH-1:0]    cnt2_out,
    output logic [ROUNDS_W-1:0] rounds_left,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]    CNT_ONE    = WIDTH'(1);
    localparam logic [ROUNDS_W-1:0] ROUNDS_ONE = ROUNDS_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    limit1;
    logic [WIDTH-1:0]    limit2;
    logic [WIDTH-1:0]    limit1_nxt;
    logic [WIDTH-1:0]    limit2_nxt;
    logic [WIDTH-1:0]    cnt1_nxt;
    logic [WIDTH-1:0]    cnt2_nxt;
    logic [ROUNDS_W-1:0] rounds_nxt;
    logic                accept;

    assign accept        = cmd.cmd_valid && (state == IDLE);
    assign cmd.cmd_ready = (state == IDLE);
    assign phase         = state;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt1_out    <= '0;
            cnt2_out    <= '0;
            rounds_left <= '0;
            limit1      <= '0;
            limit2      <= '0;
        end else begin
            state       <= state_nxt;
            cnt1_out    <= cnt1_nxt;
            cnt2_out    <= cnt2_nxt;
            rounds_left <= rounds_nxt;
            limit1      <= limit1_nxt;
            limit2      <= limit2_nxt;
        end
    end

    // Abort outranks everything outside IDLE; inside IDLE it is ignored so an
    // accept on the same edge still goes through.
    always_comb begin
        state_nxt  = state;
        cnt1_nxt   = cnt1_out;
        cnt2_nxt   = cnt2_out;
        rounds_nxt = rounds_left;
        limit1_nxt = limit1;
        limit2_nxt = limit2;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    limit1_nxt = cmd.cmd_limit1;
                    limit2_nxt = cmd.cmd_limit2;
                    rounds_nxt = cmd.cmd_rounds;
                    cnt1_nxt   = '0;
                    cnt2_nxt   = '0;
                    state_nxt  = (cmd.cmd_rounds == '0) ? DONE : RUN1;
                end
            end
            RUN1: begin
                if (cmd.abort) begin
                    state_nxt = IDLE;
                end else if (cnt1_out == limit1) begin
                    state_nxt = RUN2;
                end else begin
                    cnt1_nxt = cnt1_out + CNT_ONE;
                end
            end
            RUN2: begin
                if (cmd.abort) begin
                    state_nxt = IDLE;
                end else if (cnt2_out == limit2) begin
                    rounds_nxt = rounds_left - ROUNDS_ONE;
                    if (rounds_left == ROUNDS_ONE) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN1;
                        cnt1_nxt  = '0;
                        cnt2_nxt  = '0;
                    end
                end else begin
                    cnt2_nxt = cnt2_out + CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/counters_sequencer.md
# counters_sequencer

Controller that runs two WIDTH-bit counters in a fixed two-phase schedule: counter 1 counts up to a programmed limit, then counter 2 counts up to its limit, repeated for a programmed number of rounds. It is commanded through a valid/ready port and reports progress and a completion pulse. It sits beside the `counters` datapath in the mixed-language example, where it replaces free-running counting with host-scheduled runs.

## Interface

Parameters:
- WIDTH, 8, width of each counter and each limit.
- ROUNDS_W, 4, width of the round count.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid. Equals (state == IDLE).
- cmd_limit1  in  WIDTH  terminal value of counter 1.
- cmd_limit2  in  WIDTH  terminal value of counter 2.
- cmd_rounds  in  ROUNDS_W  number of RUN1→RUN2 rounds.
- abort  in  1  cancels an active run.
- cnt1_out  out  WIDTH  counter 1 value, registered.
- cnt2_out  out  WIDTH  counter 2 value, registered.
- rounds_left  out  ROUNDS_W  rounds not yet completed, registered.
- phase  out  2  state encoding: IDLE=0, RUN1=1, RUN2=2, DONE=3.
- busy  out  1  high when state != IDLE.
- done  out  1  high for exactly the one cycle the block spends in DONE.

## Operation

- Reset values: state IDLE, cnt1_out=0, cnt2_out=0, rounds_left=0, latched limits=0. After reset, cmd_ready=1, busy=0, done=0, phase=0.
- IDLE: the block accepts a command on any edge where cmd_valid && cmd_ready is high.
  - On accept it latches limit1, limit2 and rounds, clears both counters, and loads rounds_left=cmd_rounds.
  - Next state is RUN1, or DONE if cmd_rounds==0.
- RUN1:
  - If cnt1_out==limit1, cnt1 holds and the next state is RUN2. cnt2 is already 0.
  - Otherwise cnt1 is incremented by 1.
- RUN2:
  - If cnt2_out==limit2, rounds_left is decremented. If rounds_left was 1, the next state is DONE and both counters hold their final values. Otherwise the next state is RUN1 and both counters are cleared.
  - Otherwise cnt2 is incremented by 1.
- DONE: done=1 for one cycle; the next state is IDLE. The counters hold until the next accept.
- abort:
  - In RUN1, RUN2 or DONE, abort has highest priority. Next state is IDLE; counters and rounds_left hold; done is not asserted on the following cycle.
  - In IDLE, abort is ignored, so an accept on the same edge proceeds.
- No wrap: a limit of 2^WIDTH-1 is reached and held. Counters never exceed their latched limit.
- Command inputs are sampled only on the accept edge. Changes while busy have no effect.

## Timing

- Accept on edge k gives phase=1 and cnt1_out=0 after edge k.
- Each round is (limit1+1) cycles in RUN1 plus (limit2+1) cycles in RUN2. cnt1_out shows 0..limit1 and cnt2_out shows 0..limit2, one value per cycle.
- With R = rounds ≥ 1, DONE is entered on edge k + R·(limit1+limit2+2). IDLE and cmd_ready=1 follow on the next edge.
- With rounds==0, DONE is entered on edge k and IDLE on edge k+1.
- A new command is accepted no earlier than the edge after the block returns to IDLE. There is no back-to-back accept from DONE.
- rst asserted mid-run forces all reset values immediately, without waiting for a clock edge. The first accept is possible on the first edge after rst deasserts.

## Test plan

- Reset: hold rst for 3 edges, then release → cnt1_out=0, cnt2_out=0, phase=0, cmd_ready=1, busy=0, done=0. Assert rst asynchronously during RUN2 → outputs return to reset values before the next clk edge.
- Single round, limit1=3, limit2=2, rounds=1, accepted at edge 0 → cnt1_out shows 0,1,2,3 on edges 0–3; cnt2_out shows 0,1,2 on edges 4–6; done=1 after edge 7 only; cmd_ready=1 after edge 8.
- Multi-round minimum limits, limit1=0, limit2=0, rounds=3 → phase alternates 1,2 for 6 cycles; rounds_left steps 3→2→1→0; done after edge 6; counters cleared at each round start.
- No-wrap boundary, limit1=255, limit2=208, rounds=1 → cnt1_out reaches 255, holds, and does not wrap to 0; cnt2_out reaches 208; done after edge 465.
- Abort in RUN2, issued when cnt2_out=5 → phase=0 on the next edge; cnt2_out stays 5; done is never asserted. Abort pulsed in IDLE together with a valid command → command is still accepted.
- Handshake: hold cmd_valid high with new limits while busy → no accept and no change to the run. Command with rounds=0 → phase=3 for one cycle, done=1, counters=0.
